// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared decode constants, formats and the instruction classifier
//
// Contents:
//   UADDR_*    : microcode start addresses. UADDR_WAIT is the control unit's idle entry.
//   OP_*/F3_*  : RV32I opcode and funct3 values recognised by the decode stage.
//   imm_fmt_t  : immediate layout selector for id_imm_gen.
//   id_state_t : decode stage occupancy.
//   dec_t      : classifier result.
//   classify() : maps an instruction word to a dec_t.
package core_pkg;

    localparam logic [4:0] UADDR_LW    = 5'd0;
    localparam logic [4:0] UADDR_SW    = 5'd2;
    localparam logic [4:0] UADDR_ADD   = 5'd4;
    localparam logic [4:0] UADDR_AND   = 5'd5;
    localparam logic [4:0] UADDR_XOR   = 5'd6;
    localparam logic [4:0] UADDR_OR    = 5'd7;
    localparam logic [4:0] UADDR_ADDI  = 5'd8;
    localparam logic [4:0] UADDR_ANDI  = 5'd9;
    localparam logic [4:0] UADDR_XORI  = 5'd10;
    localparam logic [4:0] UADDR_ORI   = 5'd11;
    localparam logic [4:0] UADDR_LUI   = 5'd12;
    localparam logic [4:0] UADDR_AUIPC = 5'd13;
    localparam logic [4:0] UADDR_JAL   = 5'd14;
    localparam logic [4:0] UADDR_JALR  = 5'd16;
    localparam logic [4:0] UADDR_WAIT  = 5'd18;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_U, IMM_J} imm_fmt_t;

    typedef enum logic {ST_EMPTY, ST_BUSY} id_state_t;

    typedef struct packed {
        logic     legal;
        logic [4:0] uaddr;
        imm_fmt_t fmt;
    } dec_t;

    function automatic dec_t classify(input logic [31:0] inst);
        dec_t       d;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        opcode  = inst[6:0];
        funct3  = inst[14:12];
        funct7  = inst[31:25];
        d.legal = 1'b0;
        d.uaddr = UADDR_WAIT;
        d.fmt   = IMM_R;
        case (opcode)
            OP_LOAD: if (funct3 == F3_WORD) begin
                d.legal = 1'b1; d.uaddr = UADDR_LW; d.fmt = IMM_I;
            end
            OP_STORE: if (funct3 == F3_WORD) begin
                d.legal = 1'b1; d.uaddr = UADDR_SW; d.fmt = IMM_S;
            end
            OP_REG: if (funct7 == 7'd0) begin
                d.fmt = IMM_R;
                case (funct3)
                    F3_ADD: begin d.legal = 1'b1; d.uaddr = UADDR_ADD; end
                    F3_AND: begin d.legal = 1'b1; d.uaddr = UADDR_AND; end
                    F3_XOR: begin d.legal = 1'b1; d.uaddr = UADDR_XOR; end
                    F3_OR:  begin d.legal = 1'b1; d.uaddr = UADDR_OR;  end
                    default: d.legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                d.fmt = IMM_I;
                case (funct3)
                    F3_ADD: begin d.legal = 1'b1; d.uaddr = UADDR_ADDI; end
                    F3_AND: begin d.legal = 1'b1; d.uaddr = UADDR_ANDI; end
                    F3_XOR: begin d.legal = 1'b1; d.uaddr = UADDR_XORI; end
                    F3_OR:  begin d.legal = 1'b1; d.uaddr = UADDR_ORI;  end
                    default: d.legal = 1'b0;
                endcase
            end
            OP_LUI:   begin d.legal = 1'b1; d.uaddr = UADDR_LUI;   d.fmt = IMM_U; end
            OP_AUIPC: begin d.legal = 1'b1; d.uaddr = UADDR_AUIPC; d.fmt = IMM_U; end
            OP_JAL:   begin d.legal = 1'b1; d.uaddr = UADDR_JAL;   d.fmt = IMM_J; end
            OP_JALR: if (funct3 == F3_ADD) begin
                d.legal = 1'b1; d.uaddr = UADDR_JALR; d.fmt = IMM_I;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// rtl/id_imm_gen.sv - combinational RV32I immediate extractor
//
// Ports:
//   inst : 32-bit instruction word
//   fmt  : immediate layout (imm_fmt_t)
//   imm  : sign-extended / shifted 32-bit immediate (0 for R-type)
module id_imm_gen
    import core_pkg::*;
(
    input  logic [31:0] inst,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    // Opcode bits never contribute to an immediate.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^inst[6:0];

    always_comb begin
        imm = 32'd0;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - single-entry RV32I decode stage feeding the microcoded control unit
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   if_inst, if_pc   : instruction word and its PC from fetch
//   if_valid_inst    : fetch offers an instruction
//   id_ready         : stage accepts this cycle (combinational on rf_valid_inst)
//   rf_valid_inst    : control unit finished the held instruction
//   id_rf_valid_inst : held instruction valid for the control unit
//   decode_addr      : microcode start address (UADDR_WAIT when empty)
//   rd, rs1, rs2     : register indices of the held instruction
//   imm              : sign-extended immediate of the held instruction
//   id_pc            : PC of the held instruction
//   illegal_inst     : unsupported encoding accepted
//
// Build option ID_ILLEGAL_TRAP_EN: illegal_inst becomes sticky and the stage
// stops accepting until reset. Without it, illegal_inst is a one-cycle pulse.
module id_decode_stage
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    input  logic        if_valid_inst,
    output logic        id_ready,
    input  logic        rf_valid_inst,
    output logic        id_rf_valid_inst,
    output logic [4:0]  decode_addr,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic [31:0] id_pc,
    output logic        illegal_inst
);

    id_state_t   state;
    dec_t        dec;
    logic [31:0] imm_next;
    logic        accept;

    assign dec = classify(if_inst);

    id_imm_gen u_imm_gen (
        .inst (if_inst),
        .fmt  (dec.fmt),
        .imm  (imm_next)
    );

    // A completion frees the slot in the same cycle, so a new instruction can
    // be taken without a bubble.
`ifdef ID_ILLEGAL_TRAP_EN
    assign id_ready = !rst && !illegal_inst && ((state == ST_EMPTY) || rf_valid_inst);
`else
    assign id_ready = !rst && ((state == ST_EMPTY) || rf_valid_inst);
`endif

    assign accept = if_valid_inst && id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_EMPTY;
            id_rf_valid_inst <= 1'b0;
            decode_addr      <= UADDR_WAIT;
            rd               <= 5'd0;
            rs1              <= 5'd0;
            rs2              <= 5'd0;
            imm              <= 32'd0;
            id_pc            <= 32'd0;
            illegal_inst     <= 1'b0;
        end else begin
`ifdef ID_ILLEGAL_TRAP_EN
            if (accept && !dec.legal) begin
                illegal_inst <= 1'b1;
            end
`else
            illegal_inst <= accept && !dec.legal;
`endif
            if (accept && dec.legal) begin
                state            <= ST_BUSY;
                id_rf_valid_inst <= 1'b1;
                decode_addr      <= dec.uaddr;
                rd               <= if_inst[11:7];
                rs1              <= if_inst[19:15];
                rs2              <= if_inst[24:20];
                imm              <= imm_next;
                id_pc            <= if_pc;
            end else if ((state == ST_BUSY) && rf_valid_inst) begin
                // Also covers an illegal accept coinciding with completion:
                // the illegal word is dropped and the slot empties.
                state            <= ST_EMPTY;
                id_rf_valid_inst <= 1'b0;
                decode_addr      <= UADDR_WAIT;
            end
        end
    end

endmodule
